instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Assembles RISC-V instruction words from decoded fields (class, registers, funct, immediate) and writes them sequentially into instruction memory.
- It is the encoding counterpart of the datapath's opcode decoder, used to preload test programs in the single-cycle and pipelined cores.
- Accepts one instruction per valid/ready handshake and writes it through the instruction-memory write port.
- Range-checks immediates and flags illegal requests.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, number of words to fill before FULL; must satisfy 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  IDLE->RUN.
- clear  in  1  return to IDLE, count := 0.
- in_valid  in  1  request present.
- in_ready  out  1  combinational; high iff state==RUN.
- in_class  in  3  0=R, 1=ALU_I, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL; 6 and 7 are illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3.
- in_funct7  in  7  used by R only.
- in_imm  in  21  signed immediate.
- imem_we  out  1  write strobe, registered.
- imem_addr  out  ADDR_W  word address, registered.
- imem_wdata  out  32  encoded word, registered.
- err_illegal  out  1  one-cycle pulse, registered.
- err_range  out  1  one-cycle pulse, registered.
- count  out  ADDR_W+1  words written since clear/reset.
- full  out  1  high iff state==FULL.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-stream:
  - state=IDLE, count=0.
  - imem_we=0, imem_addr=0, imem_wdata=0, err_illegal=0, err_range=0.
- FSM states IDLE, RUN, FULL:
  - IDLE: start -> RUN.
  - RUN: an accept that writes with count==DEPTH-1 -> FULL.
  - Any state: clear -> IDLE with count=0. clear has priority over start and over an accept in the same cycle; a request offered that cycle is dropped and no write occurs.
  - FULL: holds until clear or rst.
- Accept = in_valid & in_ready.
- Latency: 1 cycle.
  - On the accept edge, imem_we=1, imem_addr=count[ADDR_W-1:0], imem_wdata=the encoded word, count+=1.
  - imem_we and the err_* outputs are high only in the single cycle after the accept; otherwise they are 0.
  - imem_addr and imem_wdata hold their last values.
- Encodings, MSB to LSB (opcode in [6:0]):
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - ALU_I: imm[11:0]|rs1|funct3|rd|0010011.
  - LOAD: same as ALU_I with opcode 0000011.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused fields are ignored.
- Range rules, on in_imm as signed 21-bit:
  - ALU_I, LOAD, STORE: -2048..2047.
  - BRANCH: -4096..4094 and imm[0]==0.
  - JAL: imm[0]==0; the full port range is legal.
  - R: no check.
- Error handling:
  - A violation gives err_range=1 for one cycle, no write, count unchanged.
  - Class 6 or 7 gives err_illegal=1, no write, count unchanged; no range check is made.
  - Both error cases consume the request (in_ready was high).
- Back-to-back accepts every cycle are sustained; addresses increment 0, 1, 2, ... with no gaps.
- Address wrap: if DEPTH==2^ADDR_W, the last write is to address 2^ADDR_W-1 and count reads 2^ADDR_W; imem_addr never wraps, because the block is FULL by then.
- A request held while in IDLE or FULL is not accepted and produces no error.

Test Plan:
- Reset, start, then send R add (rd=3, rs1=1, rs2=2, funct3=0, funct7=0) -> next cycle imem_we=1, imem_addr=0, imem_wdata=0x002081B3, count=1.
- Back-to-back stream of four requests:
  - ALU_I addi x1,x0,5 -> 0x00500093 at addr 1.
  - LOAD lw x5,8(x2) -> 0x00812283 at addr 2.
  - STORE sw x5,12(x2) -> 0x00512623 at addr 3.
  - BRANCH beq x1,x2,-4 -> 0xFE208EE3 at addr 4.
  - Also check: imem_we stays high 4 consecutive cycles and count=5.
- JAL rd=1, imm=2048 -> 0x001000EF.
- Error cases; for each check err_range pulses once, imem_we=0 and count is unchanged:
  - JAL with imm=3.
  - ALU_I with imm=2048.
  - BRANCH with imm=4096.
- Class 7 -> err_illegal pulses once, no write.
- DEPTH=4: after 4 accepts, full=1 and in_ready=0; a 5th request held 3 cycles is not accepted.
  - Then assert clear -> IDLE, count=0, full=0.
  - Then start and one accept -> write at addr 0.
- Assert rst in the cycle after an accept (mid-stream):
  - Following cycle: imem_we=0, count=0, state IDLE, in_ready=0.
  - Same cycle as clear plus a valid request: the request is dropped and no write occurs.

Source files
------------

// File: rtl/instr_encoder.sv
// Builds RV32I instruction words from decoded fields and writes them in
// order into instruction memory, one word per accepted request.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_class,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic signed [20:0]       in_imm,
    output logic                     imem_we,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     err_illegal,
    output logic                     err_range,
    output logic [ADDR_W:0]          count,
    output logic                     full
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FULL} state_t;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_ALU_I  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

    state_t state;
    logic   accept;
    logic   illegal_cls;
    logic   imm_ok;
    logic [31:0] enc_word;

    function automatic logic [31:0] encode(
        input logic [2:0]        cls,
        input logic [4:0]        rd,
        input logic [4:0]        rs1,
        input logic [4:0]        rs2,
        input logic [2:0]        f3,
        input logic [6:0]        f7,
        input logic signed [20:0] imm
    );
        case (cls)
            CLS_R:      encode = {f7, rs2, rs1, f3, rd, 7'b0110011};
            CLS_ALU_I:  encode = {imm[11:0], rs1, f3, rd, 7'b0010011};
            CLS_LOAD:   encode = {imm[11:0], rs1, f3, rd, 7'b0000011};
            CLS_STORE:  encode = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            CLS_BRANCH: encode = {imm[12], imm[10:5], rs2, rs1, f3,
                                  imm[4:1], imm[11], 7'b1100011};
            CLS_JAL:    encode = {imm[20], imm[10:1], imm[11], imm[19:12],
                                  rd, 7'b1101111};
            default:    encode = 32'h0;
        endcase
    endfunction

    function automatic logic imm_in_range(
        input logic [2:0]         cls,
        input logic signed [20:0] imm
    );
        case (cls)
            CLS_ALU_I, CLS_LOAD, CLS_STORE:
                imm_in_range = (imm >= -21'sd2048) && (imm <= 21'sd2047);
            CLS_BRANCH:
                imm_in_range = (imm >= -21'sd4096) && (imm <= 21'sd4094) && !imm[0];
            CLS_JAL:
                imm_in_range = !imm[0];
            default:
                imm_in_range = 1'b1;
        endcase
    endfunction

    assign in_ready    = (state == ST_RUN);
    assign full        = (state == ST_FULL);
    assign accept      = in_valid & in_ready;
    assign illegal_cls = (in_class == 3'd6) || (in_class == 3'd7);
    assign imm_ok      = imm_in_range(in_class, in_imm);
    assign enc_word    = encode(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

    // Registered write port and error pulses; clear beats start and any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            imem_we     <= 1'b0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
            if (clear) begin
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start) state <= ST_RUN;
                    ST_RUN: begin
                        if (accept) begin
                            if (illegal_cls) begin
                                err_illegal <= 1'b1;
                            end else if (!imm_ok) begin
                                err_range <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= count[ADDR_W-1:0];
                                imem_wdata <= enc_word;
                                count      <= count + (ADDR_W+1)'(1);
                                if (count == LAST_WORD) state <= ST_FULL;
                            end
                        end
                    end
                    ST_FULL: state <= ST_FULL;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a 256-deep and a 4-deep instance share one
// stimulus stream and are compared every cycle against a field-level model.
module tb_instr_encoder;

    logic               clk;
    logic               rst;
    logic               start;
    logic               clear;
    logic               in_valid;
    logic [2:0]         in_class;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic signed [20:0] in_imm;

    logic        b_ready, b_we, b_ei, b_er, b_full;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [8:0]  b_count;

    logic        s_ready, s_we, s_ei, s_er, s_full;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int we_run;

    instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut_big (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(b_ready), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .err_illegal(b_ei), .err_range(b_er), .count(b_count), .full(b_full)
    );

    instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(s_ready), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .err_illegal(s_ei), .err_range(s_er), .count(s_count), .full(s_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: 0=idle, 1=run, 2=full per instance; word built from field arithmetic.
    int          m_state [2];
    int          m_count [2];
    logic        m_we    [2];
    logic        m_ei    [2];
    logic        m_er    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    function automatic logic [31:0] m_enc(input int c, input int rd, input int rs1,
                                          input int rs2, input int f3, input int f7,
                                          input int imm);
        logic [31:0] u;
        logic [31:0] regs;
        u = imm;
        regs = (rs1 << 15) + (f3 << 12);
        case (c)
            0: return (f7 << 25) + (rs2 << 20) + regs + (rd << 7) + 51;
            1: return ((u & 32'hFFF) << 20) + regs + (rd << 7) + 19;
            2: return ((u & 32'hFFF) << 20) + regs + (rd << 7) + 3;
            3: return (((u >> 5) & 127) << 25) + (rs2 << 20) + regs + ((u & 31) << 7) + 35;
            4: return (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (rs2 << 20) + regs
                      + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + 99;
            default: return (((u >> 20) & 1) << 31) + (((u >> 1) & 1023) << 21)
                      + (((u >> 11) & 1) << 20) + (((u >> 12) & 255) << 12) + (rd << 7) + 111;
        endcase
    endfunction

    function automatic bit m_legal(input int c, input int imm);
        if (c >= 1 && c <= 3) return (imm >= -2048) && (imm <= 2047);
        if (c == 4) return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        if (c == 5) return (imm % 2 == 0);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_state[i] <= 0; m_count[i] <= 0; m_we[i] <= 0;
                m_ei[i] <= 0; m_er[i] <= 0; m_addr[i] <= 0; m_wdata[i] <= 0;
            end else begin
                m_we[i] <= 0; m_ei[i] <= 0; m_er[i] <= 0;
                if (clear) begin
                    m_state[i] <= 0; m_count[i] <= 0;
                end else if (m_state[i] == 0 && start) begin
                    m_state[i] <= 1;
                end else if (m_state[i] == 1 && in_valid) begin
                    if (in_class >= 6) m_ei[i] <= 1;
                    else if (!m_legal(int'(in_class), int'(in_imm))) m_er[i] <= 1;
                    else begin
                        m_we[i]    <= 1;
                        m_addr[i]  <= m_count[i];
                        m_wdata[i] <= m_enc(int'(in_class), int'(in_rd), int'(in_rs1),
                                            int'(in_rs2), int'(in_funct3), int'(in_funct7),
                                            int'(in_imm));
                        m_count[i] <= m_count[i] + 1;
                        if (m_count[i] + 1 == depth_of(i)) m_state[i] <= 2;
                    end
                end
            end
        end
    end

    task automatic cmp(input int i, input logic rdy, input logic fl, input logic we,
                       input logic ei, input logic er, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] cnt);
        string p;
        p = (i == 0) ? "big" : "small";
        chk({p, ".in_ready"}, 32'(rdy), 32'(m_state[i] == 1));
        chk({p, ".full"}, 32'(fl), 32'(m_state[i] == 2));
        chk({p, ".count"}, cnt, m_count[i]);
        chk({p, ".imem_we"}, 32'(we), 32'(m_we[i]));
        chk({p, ".err_illegal"}, 32'(ei), 32'(m_ei[i]));
        chk({p, ".err_range"}, 32'(er), 32'(m_er[i]));
        chk({p, ".imem_addr"}, addr, m_addr[i]);
        chk({p, ".imem_wdata"}, wdata, m_wdata[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, b_ready, b_full, b_we, b_ei, b_er, 32'(b_addr), b_wdata, 32'(b_count));
            cmp(1, s_ready, s_full, s_we, s_ei, s_er, 32'(s_addr), s_wdata, 32'(s_count));
        end
    end

    task automatic drive(input logic [2:0] c, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7, input int imm);
        in_valid  = 1'b1;
        in_class  = c;
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 21'(imm);
    endtask

    task automatic range_err(input string name, input logic [2:0] c, input int imm);
        @(negedge clk);
        drive(c, 1, 0, 0, 0, 0, imm);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, ".err_range"}, 32'(b_er), 32'd1);
        chk({name, ".imem_we"}, 32'(b_we), 32'd0);
        chk({name, ".count"}, 32'(b_count), 32'd6);
        @(negedge clk);
        chk({name, ".err_range_pulse"}, 32'(b_er), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        drive(3'd0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset.imem_we", 32'(b_we), 32'd0);
        chk("reset.count", 32'(b_count), 32'd0);
        chk("reset.in_ready", 32'(b_ready), 32'd0);
        chk("reset.wdata", b_wdata, 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(3'd0, 3, 1, 2, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("add.imem_we", 32'(b_we), 32'd1);
        chk("add.imem_addr", 32'(b_addr), 32'd0);
        chk("add.imem_wdata", b_wdata, 32'h002081B3);
        chk("add.count", 32'(b_count), 32'd1);

        we_run = 0;
        drive(3'd1, 1, 0, 0, 0, 0, 5);
        @(negedge clk);
        drive(3'd2, 5, 2, 0, 2, 0, 8);
        if (b_we) we_run++;
        chk("addi.wdata", b_wdata, 32'h00500093);
        chk("addi.addr", 32'(b_addr), 32'd1);
        @(negedge clk);
        drive(3'd3, 0, 2, 5, 2, 0, 12);
        if (b_we) we_run++;
        chk("lw.wdata", b_wdata, 32'h00812283);
        chk("lw.addr", 32'(b_addr), 32'd2);
        @(negedge clk);
        drive(3'd4, 0, 1, 2, 0, 0, -4);
        if (b_we) we_run++;
        chk("sw.wdata", b_wdata, 32'h00512623);
        chk("sw.addr", 32'(b_addr), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        if (b_we) we_run++;
        chk("beq.wdata", b_wdata, 32'hFE208EE3);
        chk("beq.addr", 32'(b_addr), 32'd4);
        chk("stream.we_cycles", 32'(we_run), 32'd4);
        chk("stream.count", 32'(b_count), 32'd5);
        chk("small.full_after_stream", 32'(s_full), 32'd1);
        @(negedge clk);
        chk("stream.we_low", 32'(b_we), 32'd0);

        drive(3'd5, 1, 0, 0, 0, 0, 2048);
        @(negedge clk);
        in_valid = 1'b0;
        chk("jal.wdata", b_wdata, 32'h001000EF);
        chk("jal.addr", 32'(b_addr), 32'd5);

        range_err("jal_odd", 3'd5, 3);
        range_err("addi_2048", 3'd1, 2048);
        range_err("beq_4096", 3'd4, 4096);

        @(negedge clk);
        drive(3'd7, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("cls7.err_illegal", 32'(b_ei), 32'd1);
        chk("cls7.imem_we", 32'(b_we), 32'd0);
        chk("cls7.count", 32'(b_count), 32'd6);
        @(negedge clk);
        chk("cls7.pulse", 32'(b_ei), 32'd0);

        drive(3'd1, 9, 0, 0, 0, 0, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear.imem_we", 32'(b_we), 32'd0);
        chk("clear.count", 32'(b_count), 32'd0);
        chk("clear.small_full", 32'(s_full), 32'd0);
        chk("clear.in_ready", 32'(b_ready), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(3'd1, k + 1, 0, 0, 0, 0, k);
            @(negedge clk);
        end
        chk("depth4.full", 32'(s_full), 32'd1);
        chk("depth4.count", 32'(s_count), 32'd4);
        chk("depth4.last_addr", 32'(s_addr), 32'd3);
        drive(3'd1, 7, 0, 0, 0, 0, 7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("depth4.held_ready", 32'(s_ready), 32'd0);
            chk("depth4.held_we", 32'(s_we), 32'd0);
            chk("depth4.held_count", 32'(s_count), 32'd4);
        end
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("depth4.clear_count", 32'(s_count), 32'd0);
        chk("depth4.clear_full", 32'(s_full), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(3'd0, 4, 5, 6, 0, 32, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("depth4.restart_we", 32'(s_we), 32'd1);
        chk("depth4.restart_addr", 32'(s_addr), 32'd0);
        chk("depth4.restart_wdata", s_wdata, 32'h40628233);

        drive(3'd1, 2, 0, 0, 0, 0, -1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        chk("midrst.write_seen", 32'(b_we), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.imem_we", 32'(b_we), 32'd0);
        chk("midrst.count", 32'(b_count), 32'd0);
        chk("midrst.in_ready", 32'(b_ready), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
